// File: rtl/register_file_16_if.sv
// Bus bundle for register_file_16: one write port and two registered read ports.
// The master drives requests; the slave (register file) returns read data and valid flags.
interface register_file_16_if #(
    parameter int WIDTH = 8
);
    logic             we;
    logic [3:0]       wa;
    logic [WIDTH-1:0] wd;
    logic             re_a;
    logic [3:0]       ra_a;
    logic             re_b;
    logic [3:0]       ra_b;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;
    logic             va;
    logic             vb;

    modport master (
        output we, wa, wd, re_a, ra_a, re_b, ra_b,
        input  da, db, va, vb
    );

    modport slave (
        input  we, wa, wd, re_a, ra_a, re_b, ra_b,
        output da, db, va, vb
    );
endinterface

// File: rtl/register_file_16.sv
// 16-entry register file with one write port and two independent registered read ports.
// A read that hits the address written at the same edge returns the new write data.
module register_file_16 #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    register_file_16_if.slave   bus
);

    logic [WIDTH-1:0] rf_q [16];
    logic [WIDTH-1:0] rf_d [16];
    logic [15:0]      wsel;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] da_q, da_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic             va_q, va_d;
    logic             vb_q, vb_d;

    // One-hot write select from a full 4-bit decode, address bit 0 is the LSB select.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < 16; i++) begin
            wsel[i] = bus.we && (bus.wa == 4'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_d[i] = wsel[i] ? bus.wd : rf_q[i];
        end
    end

    // Read muxes forward the write data when the write targets the address being read.
    always_comb begin
        rd_a = wsel[bus.ra_a] ? bus.wd : rf_q[bus.ra_a];
        rd_b = wsel[bus.ra_b] ? bus.wd : rf_q[bus.ra_b];
    end

    always_comb begin
        da_d = da_q;
        db_d = db_q;
        va_d = bus.re_a;
        vb_d = bus.re_b;
        if (bus.re_a) begin
            da_d = rd_a;
        end
        if (bus.re_b) begin
            db_d = rd_b;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rf_q <= '{default: '0};
            da_q <= '0;
            db_q <= '0;
            va_q <= 1'b0;
            vb_q <= 1'b0;
        end else begin
            rf_q <= rf_d;
            da_q <= da_d;
            db_q <= db_d;
            va_q <= va_d;
            vb_q <= vb_d;
        end
    end

    assign bus.da = da_q;
    assign bus.db = db_q;
    assign bus.va = va_q;
    assign bus.vb = vb_q;

endmodule

// File: tb/tb_register_file_16.sv
// Directed and random checks of register_file_16: reset, readback, forwarding, hold and mid-operation reset.
module tb_register_file_16;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic clr_n;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    logic [WIDTH-1:0] model_mem [16];
    logic [WIDTH-1:0] exp_da, exp_db;
    logic             exp_va, exp_vb;
    logic             r_we, r_re_a, r_re_b;
    logic [3:0]       r_wa, r_ra_a, r_ra_b;
    logic [WIDTH-1:0] r_wd;

    always #5 clk = ~clk;

    register_file_16_if #(.WIDTH(WIDTH)) bus ();

    register_file_16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [WIDTH-1:0] wd,
                                 input logic re_a, input logic [3:0] ra_a,
                                 input logic re_b, input logic [3:0] ra_b);
        bus.we   = we;
        bus.wa   = wa;
        bus.wd   = wd;
        bus.re_a = re_a;
        bus.ra_a = ra_a;
        bus.re_b = re_b;
        bus.ra_b = ra_b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] e_da, input logic [WIDTH-1:0] e_db,
                               input logic e_va, input logic e_vb);
        n_compared++;
        assert (bus.da === e_da) else begin
            n_mismatched++;
            $error("[TB] FAIL %s da: observed 0x%0h expected 0x%0h", tag, bus.da, e_da);
        end
        n_compared++;
        assert (bus.db === e_db) else begin
            n_mismatched++;
            $error("[TB] FAIL %s db: observed 0x%0h expected 0x%0h", tag, bus.db, e_db);
        end
        n_compared++;
        assert (bus.va === e_va) else begin
            n_mismatched++;
            $error("[TB] FAIL %s va: observed %0b expected %0b", tag, bus.va, e_va);
        end
        n_compared++;
        assert (bus.vb === e_vb) else begin
            n_mismatched++;
            $error("[TB] FAIL %s vb: observed %0b expected %0b", tag, bus.vb, e_vb);
        end
    endtask

    initial begin
        clr_n = 1'b1;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.re_a = 1'b0; bus.ra_a = '0; bus.re_b = 1'b0; bus.ra_b = '0;
        #1;
        clr_n = 1'b0;
        #1;
        checkOutput("reset_async", '0, '0, 1'b0, 1'b0);

        // Inputs toggle randomly while reset is held; nothing may leak through.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), WIDTH'($urandom), 1'($urandom), 4'($urandom),
                          1'($urandom), 4'($urandom));
            checkOutput("reset_held", '0, '0, 1'b0, 1'b0);
        end
        clr_n = 1'b1;

        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 4'(n), 1'b1, 4'(15 - n));
            checkOutput($sformatf("post_reset_read_%0d", n), '0, '0, 1'b1, 1'b1);
        end

        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, 4'(n), WIDTH'(n * 17), 1'b0, '0, 1'b0, '0);
        end
        checkOutput("write_no_read_hold", '0, '0, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 4'(n), 1'b1, 4'(15 - n));
            checkOutput($sformatf("readback_%0d", n), WIDTH'(n * 17), WIDTH'((15 - n) * 17), 1'b1, 1'b1);
        end

        applyStimulus(1'b1, 4'd5, 8'h3C, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 4'd5, 8'hA7, 1'b1, 4'd5, 1'b1, 4'd5);
        checkOutput("forward_both", 8'hA7, 8'hA7, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, '0);
        checkOutput("forward_stored", 8'hA7, 8'hA7, 1'b1, 1'b0);

        applyStimulus(1'b1, 4'd2, 8'h55, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0, '0);
        checkOutput("hold_read", 8'h55, 8'hA7, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd2, 8'h66, 1'b0, '0, 1'b0, '0);
        checkOutput("hold_after_write", 8'h55, 8'hA7, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd2);
        checkOutput("hold_b_new", 8'h55, 8'h66, 1'b0, 1'b1);

        applyStimulus(1'b1, 4'd15, 8'h5A, 1'b1, 4'd0, 1'b1, 4'd15);
        checkOutput("forward_b_only", 8'h00, 8'h5A, 1'b1, 1'b1);

        applyStimulus(1'b1, 4'd9, 8'hFF, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd9, 1'b1, 4'd9);
        checkOutput("pre_midreset", 8'hFF, 8'hFF, 1'b1, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("midreset_async", '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 8'h77, 1'b1, 4'd9, 1'b1, 4'd9);
        checkOutput("midreset_discard", '0, '0, 1'b0, 1'b0);
        clr_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd9, 1'b1, 4'd3);
        checkOutput("midreset_cleared", '0, '0, 1'b1, 1'b1);

        // Random traffic against a behavioural model; storage is all-zero after the reset above.
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        exp_da = '0;
        exp_db = '0;
        for (int i = 0; i < 2000; i++) begin
            r_we   = 1'($urandom);
            r_wa   = 4'($urandom);
            r_wd   = WIDTH'($urandom);
            r_re_a = 1'($urandom);
            r_ra_a = 4'($urandom);
            r_re_b = 1'($urandom);
            r_ra_b = 4'($urandom);
            exp_va = r_re_a;
            exp_vb = r_re_b;
            if (r_re_a) exp_da = (r_we && r_wa == r_ra_a) ? r_wd : model_mem[r_ra_a];
            if (r_re_b) exp_db = (r_we && r_wa == r_ra_b) ? r_wd : model_mem[r_ra_b];
            if (r_we) model_mem[r_wa] = r_wd;
            applyStimulus(r_we, r_wa, r_wd, r_re_a, r_ra_a, r_re_b, r_ra_b);
            checkOutput($sformatf("random_%0d", i), exp_da, exp_db, exp_va, exp_vb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
